snapshot_ctrl: RTL and testbench

//  Sequences single-partition bus accesses into snapshot_reg strobes for one wide register.

---
 rtl/snapshot_ctrl.sv | 156 +++++++++++++++
 tb/tb_snapshot_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/snapshot_ctrl.sv
// rtl/snapshot_ctrl.sv - sequences partition accesses into snapshot_reg strobes
module snapshot_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_WIDTH     = 64,
    parameter int PARTITION_CNT = REG_WIDTH / DATA_WIDTH,
    parameter int IDX_WIDTH     = (PARTITION_CNT > 1) ? $clog2(PARTITION_CNT) : 1,
    parameter int STRICT_WR     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     soft_rst,
    input  logic                     req_vld,
    output logic                     req_rdy,
    input  logic                     req_wr,
    input  logic [IDX_WIDTH-1:0]     req_idx,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     ack_vld,
    output logic                     ack_err,
    output logic [DATA_WIDTH-1:0]    ack_rdata,
    output logic [PARTITION_CNT-1:0] snap_rd_en,
    output logic [PARTITION_CNT-1:0] snap_wr_en,
    output logic [REG_WIDTH-1:0]     snap_wr_data,
    input  logic [REG_WIDTH-1:0]     snap_rd_data,
    output logic                     snap_busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    localparam logic [PARTITION_CNT-1:0] LP_BIT0 = PARTITION_CNT'(1);

    state_t                   r_state;
    logic                     r_req_rdy;
    logic                     r_wr;
    logic [IDX_WIDTH-1:0]     r_idx;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic                     r_ack_vld;
    logic                     r_ack_err;
    logic [DATA_WIDTH-1:0]    r_ack_rdata;
    logic                     r_rd_valid;
    logic [PARTITION_CNT-1:0] r_wr_mask;

    logic [31:0]              w_idx_ext;
    logic                     w_idx_ok;
    logic                     w_idx_zero;
    logic                     w_upper_full;
    logic                     w_legal;
    logic                     w_fire;
    logic [PARTITION_CNT-1:0] w_onehot;
    logic [DATA_WIDTH-1:0]    w_rd_word;

    assign w_idx_ext    = 32'(r_idx);
    assign w_idx_ok     = w_idx_ext < PARTITION_CNT;
    assign w_idx_zero   = (r_idx == '0);
    // bit 0 of the mask is never set, so force it when testing the upper partitions
    assign w_upper_full = &(r_wr_mask | LP_BIT0);
    assign w_onehot     = LP_BIT0 << r_idx;
    assign w_rd_word    = DATA_WIDTH'(snap_rd_data >> (w_idx_ext * DATA_WIDTH));
    assign w_fire       = (r_state == S_ISSUE) && !soft_rst && w_legal;

    // ordering legality of the registered request against the tracking state
    always_comb begin
        w_legal = 1'b0;
        if (w_idx_ok) begin
            if (PARTITION_CNT == 1)
                w_legal = 1'b1;
            else if (!r_wr)
                w_legal = w_idx_zero | r_rd_valid;
            else if (!w_idx_zero)
                w_legal = 1'b1;
            else
                w_legal = (STRICT_WR == 0) | w_upper_full;
        end
    end

    assign snap_rd_en   = (w_fire && !r_wr) ? w_onehot : '0;
    assign snap_wr_en   = (w_fire &&  r_wr) ? w_onehot : '0;
    assign snap_wr_data = {PARTITION_CNT{r_wdata}};
    assign snap_busy    = r_rd_valid | (|r_wr_mask);
    assign req_rdy      = r_req_rdy;
    assign ack_vld      = r_ack_vld;
    assign ack_err      = r_ack_err;
    assign ack_rdata    = r_ack_rdata;

    // request FSM, acknowledge generation and read/write order tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_req_rdy   <= 1'b1;
            r_wr        <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_ack_vld   <= 1'b0;
            r_ack_err   <= 1'b0;
            r_ack_rdata <= '0;
            r_rd_valid  <= 1'b0;
            r_wr_mask   <= '0;
        end else if (soft_rst) begin
            r_state     <= S_IDLE;
            r_req_rdy   <= 1'b1;
            r_ack_vld   <= 1'b0;
            r_ack_err   <= 1'b0;
            r_ack_rdata <= '0;
            r_rd_valid  <= 1'b0;
            r_wr_mask   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_vld) begin
                        r_wr      <= req_wr;
                        r_idx     <= req_idx;
                        r_wdata   <= req_wdata;
                        r_req_rdy <= 1'b0;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_ack_vld   <= 1'b1;
                    r_ack_err   <= !w_legal;
                    r_ack_rdata <= (w_legal && !r_wr) ? w_rd_word : '0;
                    if (PARTITION_CNT > 1) begin
                        if (!r_wr) begin
                            // a partition-0 read reloads the snapshot, discarding staged writes
                            if (w_legal && w_idx_zero) begin
                                r_rd_valid <= 1'b1;
                                r_wr_mask  <= '0;
                            end
                        end else if (w_idx_zero) begin
                            // any commit attempt, accepted or not, restarts write staging
                            r_wr_mask <= '0;
                        end else if (w_legal) begin
                            r_wr_mask  <= r_wr_mask | w_onehot;
                            r_rd_valid <= 1'b0;
                        end
                    end
                    r_state <= S_RESP;
                end
                S_RESP: begin
                    r_ack_vld   <= 1'b0;
                    r_ack_err   <= 1'b0;
                    r_ack_rdata <= '0;
                    r_req_rdy   <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_req_rdy <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snapshot_ctrl.sv
// tb/tb_snapshot_ctrl.sv - scoreboard bench for snapshot_ctrl
module tb_snapshot_ctrl;

    logic        clk;
    logic        rst_n;
    logic        soft_rst;

    logic        req_vld, req_rdy, req_wr;
    logic [0:0]  req_idx;
    logic [31:0] req_wdata;
    logic        ack_vld, ack_err;
    logic [31:0] ack_rdata;
    logic [1:0]  snap_rd_en, snap_wr_en;
    logic [63:0] snap_wr_data, snap_rd_data;
    logic        snap_busy;

    logic        req_vld3, req_rdy3, req_wr3;
    logic [1:0]  req_idx3;
    logic [31:0] req_wdata3;
    logic        ack_vld3, ack_err3;
    logic [31:0] ack_rdata3;
    logic [2:0]  snap_rd_en3, snap_wr_en3;
    logic [95:0] snap_wr_data3, snap_rd_data3;
    logic        snap_busy3;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] exp_q[$];
    logic [32:0] exp_q3[$];

    snapshot_ctrl #(.DATA_WIDTH(32), .REG_WIDTH(64), .STRICT_WR(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
        .req_idx(req_idx), .req_wdata(req_wdata),
        .ack_vld(ack_vld), .ack_err(ack_err), .ack_rdata(ack_rdata),
        .snap_rd_en(snap_rd_en), .snap_wr_en(snap_wr_en),
        .snap_wr_data(snap_wr_data), .snap_rd_data(snap_rd_data),
        .snap_busy(snap_busy)
    );

    snapshot_ctrl #(.DATA_WIDTH(32), .REG_WIDTH(96), .STRICT_WR(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .soft_rst(soft_rst),
        .req_vld(req_vld3), .req_rdy(req_rdy3), .req_wr(req_wr3),
        .req_idx(req_idx3), .req_wdata(req_wdata3),
        .ack_vld(ack_vld3), .ack_err(ack_err3), .ack_rdata(ack_rdata3),
        .snap_rd_en(snap_rd_en3), .snap_wr_en(snap_wr_en3),
        .snap_wr_data(snap_wr_data3), .snap_rd_data(snap_rd_data3),
        .snap_busy(snap_busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // completions from the 2-partition instance
    always @(negedge clk) begin
        if (rst_n && ack_vld) begin
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", 1'b1, 1'b0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("ack_err", ack_err, e[32]);
                chk("ack_rdata", ack_rdata, e[31:0]);
            end
        end
    end

    // completions from the 3-partition instance
    always @(negedge clk) begin
        if (rst_n && ack_vld3) begin
            if (exp_q3.size() == 0) begin
                chk("ack3_unexpected", 1'b1, 1'b0);
            end else begin
                logic [32:0] e;
                e = exp_q3.pop_front();
                chk("ack3_err", ack_err3, e[32]);
                chk("ack3_rdata", ack_rdata3, e[31:0]);
            end
        end
    end

    task automatic do_req(input logic wr, input logic [0:0] idx, input logic [31:0] wd,
                          input logic exp_err, input string tag);
        int n;
        logic [31:0] erd;
        logic [1:0]  oh;
        n = 0;
        while (!req_rdy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, req_rdy, 1'b1);
        req_vld   = 1'b1;
        req_wr    = wr;
        req_idx   = idx;
        req_wdata = wd;
        oh  = (idx == 1'b1) ? 2'b10 : 2'b01;
        erd = (wr || exp_err) ? 32'h0 : ((idx == 1'b1) ? snap_rd_data[63:32] : snap_rd_data[31:0]);
        exp_q.push_back({exp_err, erd});
        @(negedge clk);
        req_vld = 1'b0;
        chk({tag, "_rd_en"}, snap_rd_en, (!wr && !exp_err) ? oh : 2'b00);
        chk({tag, "_wr_en"}, snap_wr_en, ( wr && !exp_err) ? oh : 2'b00);
        if (wr) chk({tag, "_wr_data"}, snap_wr_data, {wd, wd});
        chk({tag, "_rdy_busy"}, req_rdy, 1'b0);
        @(negedge clk);
        chk({tag, "_ack_vld"}, ack_vld, 1'b1);
        @(negedge clk);
    endtask

    task automatic do_req3(input logic wr, input logic [1:0] idx, input logic [31:0] wd,
                           input logic exp_err, input string tag);
        int n;
        logic [31:0] erd;
        n = 0;
        while (!req_rdy3 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_rdy"}, req_rdy3, 1'b1);
        req_vld3   = 1'b1;
        req_wr3    = wr;
        req_idx3   = idx;
        req_wdata3 = wd;
        erd = (wr || exp_err) ? 32'h0 : 32'(snap_rd_data3 >> (32 * int'(idx)));
        exp_q3.push_back({exp_err, erd});
        @(negedge clk);
        req_vld3 = 1'b0;
        n = 0;
        while (!ack_vld3 && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ack_vld"}, ack_vld3, 1'b1);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; soft_rst = 1'b0;
        req_vld = 1'b0; req_wr = 1'b0; req_idx = '0; req_wdata = '0;
        req_vld3 = 1'b0; req_wr3 = 1'b0; req_idx3 = '0; req_wdata3 = '0;
        snap_rd_data  = 64'hAAAA_BBBB_CCCC_DDDD;
        snap_rd_data3 = 96'h3333_3333_2222_2222_1111_1111;
        repeat (2) @(negedge clk);
        chk("rst_rdy", req_rdy, 1'b1);
        chk("rst_ack_vld", ack_vld, 1'b0);
        chk("rst_ack_err", ack_err, 1'b0);
        chk("rst_ack_rdata", ack_rdata, 32'h0);
        chk("rst_strobes", {snap_rd_en, snap_wr_en}, 4'h0);
        chk("rst_busy", snap_busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(1'b0, 1'b1, 32'h0, 1'b1, "rd1_after_rst");
        do_req(1'b0, 1'b0, 32'h0, 1'b0, "rd0");
        chk("busy_after_rd0", snap_busy, 1'b1);
        do_req(1'b0, 1'b1, 32'h0, 1'b0, "rd1");

        do_req(1'b1, 1'b1, 32'h1234_5678, 1'b0, "wr1");
        chk("busy_after_wr1", snap_busy, 1'b1);
        do_req(1'b1, 1'b0, 32'h9ABC_DEF0, 1'b0, "wr0_commit");
        chk("busy_after_commit", snap_busy, 1'b0);

        do_req(1'b1, 1'b0, 32'h5555_0000, 1'b1, "wr0_empty");
        do_req(1'b1, 1'b1, 32'h0000_1111, 1'b0, "wr1_b");
        do_req(1'b0, 1'b0, 32'h0, 1'b0, "rd0_b");
        do_req(1'b1, 1'b0, 32'h2222_0000, 1'b1, "wr0_after_rd");

        do_req(1'b0, 1'b0, 32'h0, 1'b0, "rd0_c");
        do_req(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, "wr1_c");
        do_req(1'b0, 1'b1, 32'h0, 1'b1, "rd1_stale");
        do_req(1'b0, 1'b1, 32'h0, 1'b1, "rd1_stale_again");

        do_req(1'b0, 1'b0, 32'h0, 1'b0, "rd0_d");
        req_vld = 1'b1; req_wr = 1'b1; req_idx = 1'b1; req_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        req_vld  = 1'b0;
        soft_rst = 1'b1;
        #1;
        chk("srst_strobes", {snap_rd_en, snap_wr_en}, 4'h0);
        @(negedge clk);
        soft_rst = 1'b0;
        chk("srst_rdy", req_rdy, 1'b1);
        chk("srst_busy", snap_busy, 1'b0);
        repeat (3) @(negedge clk);
        do_req(1'b0, 1'b1, 32'h0, 1'b1, "rd1_after_srst");

        do_req3(1'b0, 2'd3, 32'h0, 1'b1, "p3_rd3_range");
        do_req3(1'b0, 2'd0, 32'h0, 1'b0, "p3_rd0");
        do_req3(1'b0, 2'd2, 32'h0, 1'b0, "p3_rd2");
        do_req3(1'b1, 2'd3, 32'h7777_7777, 1'b1, "p3_wr3_range");
        do_req3(1'b1, 2'd1, 32'h0101_0101, 1'b0, "p3_wr1");
        do_req3(1'b1, 2'd0, 32'h0000_0000, 1'b1, "p3_wr0_partial");
        do_req3(1'b1, 2'd1, 32'h0101_0101, 1'b0, "p3_wr1_b");
        do_req3(1'b1, 2'd2, 32'h0202_0202, 1'b0, "p3_wr2_b");
        do_req3(1'b1, 2'd0, 32'h0000_0000, 1'b0, "p3_wr0_commit");
        chk("p3_busy_after_commit", snap_busy3, 1'b0);

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("queue3_drained", exp_q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
